kuznechik_apb_master: RTL and testbench
=======================================

Name: kuznechik_apb_master

Overview:
APB initiator that runs one full encryption on the memory-mapped Kuznechik cipher peripheral.
- Takes a 128-bit block on a valid/ready command port.
- Performs the register sequence over APB: reset release, data load, request, VALID poll, result read, acknowledge.
- Returns the 128-bit result on a valid/ready response port.
- Sits between a local accelerator front-end and the APB bus, with the cipher peripheral as its slave.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width.
- APB_DATA_WIDTH, 32, APB data width; fixed at 32 (four words per block).
- BASE_ADDR, 12'h000, peripheral base address, added to every register offset.
- POLL_TIMEOUT, 1024, maximum VALID reads before abort (used only when the optional feature is enabled).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; asynchronous, active-low.
- cmd_valid_i  in  1  block available on cmd_data_i.
- cmd_ready_o  out  1  master idle; command accepted when cmd_valid_i & cmd_ready_o.
- cmd_data_i  in  128  plaintext block; word k = bits [32k+31:32k].
- res_valid_o  out  1  result (or error) available.
- res_ready_i  in  1  consumer takes the result.
- res_data_o  out  128  ciphertext.
- res_err_o  out  1  transaction aborted (PSLVERR or timeout).
- busy_o  out  1  sequence in progress.
- apb_paddr_o  out  APB_ADDR_WIDTH  address.
- apb_pwdata_o  out  32  write data.
- apb_pwrite_o  out  1  1 = write.
- apb_psel_o  out  1  select.
- apb_penable_o  out  1  access phase.
- apb_prdata_i  in  32  read data.
- apb_pready_i  in  1  slave ready.
- apb_pslverr_i  in  1  slave error.

Behaviour:
- Register offsets:
  - RST 0x00, REQ 0x04, ACK 0x08, VALID 0x0C.
  - DATA_IN_0..3 0x14/0x18/0x1C/0x20.
  - DATA_OUT_0..3 0x24/0x28/0x2C/0x30.
- Reset values: cmd_ready_o=1; all other outputs 0 (res_valid_o, res_err_o, busy_o, apb_psel_o, apb_penable_o, apb_pwrite_o, apb_paddr_o, apb_pwdata_o, res_data_o). init_done flag=0.
- APB transfer engine:
  - SETUP cycle: psel=1, penable=0, with addr, write and wdata stable.
  - ACCESS: psel=1, penable=1, held until pready=1.
  - On the pready cycle: capture prdata (reads) and pslverr.
  - Next cycle: psel and penable drop to 0; no back-to-back ACCESS.
  - Every transfer takes at least 2 cycles; wait states are unbounded.
  - paddr, pwrite and pwdata do not change between SETUP and the pready cycle.
- Sequencer FSM, one APB transfer per step:
  - IDLE: cmd_ready_o=1. On accept, latch cmd_data_i, set busy_o=1, go to INIT if init_done=0, else LOAD.
  - INIT: write RST=0x1; set init_done=1.
  - LOAD: write DATA_IN_0, 1, 2, 3 in order (2-bit word counter).
  - REQ: write REQ=0x1.
  - POLL: read VALID. If bit0=1 go to READ, else repeat POLL (new SETUP).
  - READ: read DATA_OUT_0..3 into res_data_o[31:0]..[127:96].
  - ACK: write ACK=0x1.
  - DONE: res_valid_o=1, busy_o=0, held until res_ready_i; then go to IDLE.
- Error handling:
  - pslverr=1 on any pready cycle: skip all remaining steps, go to DONE with res_err_o=1.
  - res_data_o holds the partial data; init_done is cleared.
  - res_err_o clears when the result is taken.
- Command port:
  - cmd_ready_o=0 from accept until res_valid_o & res_ready_i.
  - Simultaneous res handshake and cmd_valid_i: the new command is accepted the cycle after IDLE is re-entered, never the same cycle.
- Reset mid-operation: asynchronous; psel and penable fall immediately, the FSM returns to IDLE, and init_done clears, so the next command repeats INIT.

Optional Feature:
- KUZ_APB_MASTER_TIMEOUT_EN defined:
  - POLL counts VALID reads.
  - When POLL_TIMEOUT reads all return 0: write ACK is skipped, go to DONE with res_err_o=1, init_done cleared.
  - The counter resets on every accepted command.
- Undefined: POLL repeats indefinitely, with no counter logic.

Test Plan:
- Reset, then command pt=1122334455667700ffeeddccbbaa9988 against a slave model with zero-wait pready and GOST key → APB trace is:
  - W 0x00=1; W 0x14=bbaa9988, 0x18=ffeeddcc, 0x1C=55667700, 0x20=11223344;
  - W 0x04=1; R 0x0C…; R 0x24..0x30; W 0x08=1;
  - result res_data_o=7f679d90bebc24305a468d42b9d4edcd, res_err_o=0.
- Second command after first → no RST write; first transfer is W 0x14.
- Slave inserts 3 wait states on every transfer → penable held 4 cycles each, addr/wdata stable; result identical.
- Slave returns pslverr on the W 0x18 → no further transfers; res_valid_o=1, res_err_o=1; next command restarts with W 0x00.
- With KUZ_APB_MASTER_TIMEOUT_EN and POLL_TIMEOUT=4, VALID stuck at 0 → exactly 4 R 0x0C, no ACK write, res_err_o=1.
- rstn_i asserted during the ACCESS of R 0x28 → psel=0 in the same cycle, cmd_ready_o=1; next command begins with W 0x00.

Source files
------------

// File: rtl/kuznechik_apb_master.sv
// rtl/kuznechik_apb_master.sv - APB initiator running one Kuznechik block encryption per command
// Optional: define KUZ_APB_MASTER_TIMEOUT_EN to abort VALID polling after POLL_TIMEOUT reads.

module kuznechik_apb_master #(
   parameter int                        APB_ADDR_WIDTH = 12,
   parameter int                        APB_DATA_WIDTH = 32,
   parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int                        POLL_TIMEOUT   = 1024
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic [127:0]              cmd_data_i,
   output logic                      res_valid_o,
   input  logic                      res_ready_i,
   output logic [127:0]              res_data_o,
   output logic                      res_err_o,
   output logic                      busy_o,
   output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
   output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
   output logic                      apb_pwrite_o,
   output logic                      apb_psel_o,
   output logic                      apb_penable_o,
   input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
   input  logic                      apb_pready_i,
   input  logic                      apb_pslverr_i
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_INIT = 3'd1;
   localparam logic [2:0] S_LOAD = 3'd2;
   localparam logic [2:0] S_REQ  = 3'd3;
   localparam logic [2:0] S_POLL = 3'd4;
   localparam logic [2:0] S_READ = 3'd5;
   localparam logic [2:0] S_ACK  = 3'd6;
   localparam logic [2:0] S_DONE = 3'd7;

   if (APB_DATA_WIDTH != 32 || POLL_TIMEOUT < 1) begin : g_bad_cfg
      $error("kuznechik_apb_master: APB_DATA_WIDTH must be 32 and POLL_TIMEOUT at least 1");
   end

   logic [2:0]   state;
   logic [1:0]   word;
   logic         init_done;
   logic [127:0] blk;
   logic [7:0]   nxt_off;
   logic         nxt_write;
   logic [31:0]  nxt_wdata;

`ifdef KUZ_APB_MASTER_TIMEOUT_EN
   localparam int PCW = $clog2(POLL_TIMEOUT + 1);
   logic [PCW-1:0] poll_cnt;
`endif

   // Register offset and payload of the transfer belonging to the current step.
   always_comb begin
      nxt_off   = 8'h00;
      nxt_write = 1'b0;
      nxt_wdata = 32'h0;
      case (state)
         S_INIT: begin
            nxt_write = 1'b1;
            nxt_wdata = 32'h1;
         end
         S_LOAD: begin
            nxt_off   = 8'h14 + {4'h0, word, 2'b00};
            nxt_write = 1'b1;
            nxt_wdata = blk[{word, 5'b0} +: 32];
         end
         S_REQ: begin
            nxt_off   = 8'h04;
            nxt_write = 1'b1;
            nxt_wdata = 32'h1;
         end
         S_POLL: nxt_off = 8'h0C;
         S_READ: nxt_off = 8'h24 + {4'h0, word, 2'b00};
         S_ACK: begin
            nxt_off   = 8'h08;
            nxt_write = 1'b1;
            nxt_wdata = 32'h1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state         <= S_IDLE;
         word          <= 2'd0;
         init_done     <= 1'b0;
         blk           <= '0;
         cmd_ready_o   <= 1'b1;
         res_valid_o   <= 1'b0;
         res_data_o    <= '0;
         res_err_o     <= 1'b0;
         busy_o        <= 1'b0;
         apb_paddr_o   <= '0;
         apb_pwdata_o  <= '0;
         apb_pwrite_o  <= 1'b0;
         apb_psel_o    <= 1'b0;
         apb_penable_o <= 1'b0;
`ifdef KUZ_APB_MASTER_TIMEOUT_EN
         poll_cnt      <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid_i && cmd_ready_o) begin
                  blk         <= cmd_data_i;
                  word        <= 2'd0;
                  cmd_ready_o <= 1'b0;
                  busy_o      <= 1'b1;
                  state       <= init_done ? S_LOAD : S_INIT;
`ifdef KUZ_APB_MASTER_TIMEOUT_EN
                  poll_cnt    <= '0;
`endif
               end
            end
            S_DONE: begin
               if (res_ready_i) begin
                  res_valid_o <= 1'b0;
                  res_err_o   <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            default: begin
               // One transfer per step: idle -> SETUP -> ACCESS (until pready) -> idle.
               if (!apb_psel_o) begin
                  apb_psel_o   <= 1'b1;
                  apb_paddr_o  <= BASE_ADDR + APB_ADDR_WIDTH'(nxt_off);
                  apb_pwrite_o <= nxt_write;
                  apb_pwdata_o <= nxt_wdata;
               end else if (!apb_penable_o) begin
                  apb_penable_o <= 1'b1;
               end else if (apb_pready_i) begin
                  apb_psel_o    <= 1'b0;
                  apb_penable_o <= 1'b0;
                  if (apb_pslverr_i) begin
                     state       <= S_DONE;
                     res_valid_o <= 1'b1;
                     res_err_o   <= 1'b1;
                     busy_o      <= 1'b0;
                     init_done   <= 1'b0;
                  end else begin
                     case (state)
                        S_INIT: begin
                           init_done <= 1'b1;
                           state     <= S_LOAD;
                        end
                        S_LOAD: begin
                           word <= word + 2'd1;
                           if (word == 2'd3) state <= S_REQ;
                        end
                        S_REQ: state <= S_POLL;
                        S_POLL: begin
                           if (apb_prdata_i[0]) begin
                              word  <= 2'd0;
                              state <= S_READ;
                           end
`ifdef KUZ_APB_MASTER_TIMEOUT_EN
                           else if (poll_cnt == PCW'(POLL_TIMEOUT - 1)) begin
                              state       <= S_DONE;
                              res_valid_o <= 1'b1;
                              res_err_o   <= 1'b1;
                              busy_o      <= 1'b0;
                              init_done   <= 1'b0;
                           end else begin
                              poll_cnt <= poll_cnt + 1'b1;
                           end
`endif
                        end
                        S_READ: begin
                           res_data_o[{word, 5'b0} +: 32] <= apb_prdata_i;
                           word <= word + 2'd1;
                           if (word == 2'd3) state <= S_ACK;
                        end
                        S_ACK: begin
                           state       <= S_DONE;
                           res_valid_o <= 1'b1;
                           busy_o      <= 1'b0;
                        end
                        default: ;
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kuznechik_apb_master.sv
// tb/tb_kuznechik_apb_master.sv - directed scoreboard bench for kuznechik_apb_master with an APB cipher slave model

module tb_kuznechik_apb_master;

   localparam logic [127:0] GOST_PT = 128'h1122334455667700ffeeddccbbaa9988;
   localparam logic [127:0] GOST_CT = 128'h7f679d90bebc24305a468d42b9d4edcd;

   typedef struct packed {
      logic        we;
      logic [11:0] addr;
      logic [31:0] data;
   } tr_t;

   typedef struct packed {
      logic         err;
      logic [127:0] data;
   } res_t;

   logic         clk, rstn_i;
   logic         cmd_valid, cmd_ready;
   logic [127:0] cmd_data;
   logic         res_valid, res_ready, res_err, busy;
   logic [127:0] res_data;
   logic [11:0]  paddr;
   logic [31:0]  pwdata, prdata;
   logic         pwrite, psel, penable, pready, pslverr;

   kuznechik_apb_master #(
      .APB_ADDR_WIDTH(12),
      .APB_DATA_WIDTH(32),
      .BASE_ADDR     (12'h000),
      .POLL_TIMEOUT  (4)
   ) dut (
      .clk_i        (clk),
      .rstn_i       (rstn_i),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_data_i   (cmd_data),
      .res_valid_o  (res_valid),
      .res_ready_i  (res_ready),
      .res_data_o   (res_data),
      .res_err_o    (res_err),
      .busy_o       (busy),
      .apb_paddr_o  (paddr),
      .apb_pwdata_o (pwdata),
      .apb_pwrite_o (pwrite),
      .apb_psel_o   (psel),
      .apb_penable_o(penable),
      .apb_prdata_i (prdata),
      .apb_pready_i (pready),
      .apb_pslverr_i(pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_assert = 0;
   int   n_fail   = 0;
   tr_t  exp_tr[$];
   tr_t  act_tr[$];
   res_t exp_res[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] model_ct(input logic [127:0] pt);
      return (pt == GOST_PT) ? GOST_CT : ~pt;
   endfunction

   // Cipher peripheral model, evaluated on the falling edge.
   int           waits = 0;
   int           valid_delay = 2;
   bit           valid_stuck = 0;
   bit           err_armed = 0;
   logic [11:0]  err_addr = 12'h0;
   logic [31:0]  din [4];
   logic [127:0] ct_reg = '0;
   int           polls_left = 0;
   logic [44:0]  s_hold;
   int           acc_n = 0;
   int           run_len = 0;

   always @(negedge clk) begin
      if (!rstn_i) begin
         pready  = 1'b0;
         pslverr = 1'b0;
         prdata  = 32'h0;
         run_len = 0;
      end else begin
         if (penable) run_len++;
         else if (run_len > 0) begin
            chk("penable_len", run_len, waits + 1);
            run_len = 0;
         end
         if (psel && !penable) begin
            s_hold  = {pwrite, paddr, pwdata};
            acc_n   = 0;
            pready  = 1'b0;
            pslverr = 1'b0;
         end else if (psel && penable) begin
            chk("apb_hold", {pwrite, paddr, pwdata}, s_hold);
            acc_n++;
            if (acc_n > waits) begin
               pready  = 1'b1;
               pslverr = err_armed && pwrite && (paddr == err_addr);
               if (pslverr) err_armed = 0;
               prdata  = 32'h0;
               if (pwrite) begin
                  if (paddr >= 12'h014 && paddr <= 12'h020) din[(paddr - 12'h014) >> 2] = pwdata;
                  if (paddr == 12'h004) begin
                     ct_reg     = model_ct({din[3], din[2], din[1], din[0]});
                     polls_left = valid_delay;
                  end
               end else if (paddr == 12'h00C) begin
                  if (!valid_stuck && polls_left == 0) prdata = 32'h1;
                  else if (polls_left > 0) polls_left--;
               end else if (paddr >= 12'h024 && paddr <= 12'h030) begin
                  prdata = ct_reg[((paddr - 12'h024) >> 2) * 32 +: 32];
               end
               act_tr.push_back({pwrite, paddr, pwrite ? pwdata : prdata});
            end else begin
               pready = 1'b0;
            end
         end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
         end
      end
   end

   task automatic push_tr(input logic we, input logic [11:0] a, input logic [31:0] d);
      tr_t t;
      t.we = we; t.addr = a; t.data = d;
      exp_tr.push_back(t);
   endtask

   task automatic push_res(input logic err, input logic [127:0] d);
      res_t r;
      r.err = err; r.data = d;
      exp_res.push_back(r);
   endtask

   task automatic exp_cmd(input logic [127:0] pt, input bit init, input int nzero);
      logic [127:0] ct;
      ct = model_ct(pt);
      if (init) push_tr(1'b1, 12'h000, 32'h1);
      for (int k = 0; k < 4; k++) push_tr(1'b1, 12'h014 + 12'(4 * k), pt[32 * k +: 32]);
      push_tr(1'b1, 12'h004, 32'h1);
      for (int i = 0; i < nzero; i++) push_tr(1'b0, 12'h00C, 32'h0);
      push_tr(1'b0, 12'h00C, 32'h1);
      for (int k = 0; k < 4; k++) push_tr(1'b0, 12'h024 + 12'(4 * k), ct[32 * k +: 32]);
      push_tr(1'b1, 12'h008, 32'h1);
      push_res(1'b0, ct);
   endtask

   task automatic send(input logic [127:0] pt);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = pt;
      for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
      chk("cmd_accept", cmd_ready, 1'b1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("busy_after_accept", busy, 1'b1);
      chk("cmd_ready_after_accept", cmd_ready, 1'b0);
   endtask

   task automatic collect(input bit also_cmd, input logic [127:0] next_pt);
      res_t e;
      int   n;
      @(negedge clk);
      res_ready = 1'b1;
      if (also_cmd) begin
         cmd_valid = 1'b1;
         cmd_data  = next_pt;
      end
      for (int i = 0; i < 2000 && !res_valid; i++) @(negedge clk);
      chk("res_valid_seen", res_valid, 1'b1);
      chk("exp_res_avail", exp_res.size() > 0, 1'b1);
      if (exp_res.size() > 0) begin
         e = exp_res.pop_front();
         chk("res_err", res_err, e.err);
         if (!e.err) chk("res_data", res_data, e.data);
      end
      chk("busy_in_done", busy, 1'b0);
      chk("cmd_ready_in_done", cmd_ready, 1'b0);
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      chk("res_valid_clear", res_valid, 1'b0);
      chk("res_err_clear", res_err, 1'b0);
      chk("cmd_ready_back", cmd_ready, 1'b1);
      if (also_cmd) begin
         chk("no_same_cycle_accept", busy, 1'b0);
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
         chk("accept_next_cycle", busy, 1'b1);
         chk("cmd_ready_low_next", cmd_ready, 1'b0);
      end
      chk("trace_len", act_tr.size(), exp_tr.size());
      n = (act_tr.size() < exp_tr.size()) ? act_tr.size() : exp_tr.size();
      for (int i = 0; i < n; i++) chk($sformatf("trace[%0d]", i), act_tr[i], exp_tr[i]);
      act_tr.delete();
      exp_tr.delete();
   endtask

   initial begin
      logic [127:0] pt;
      logic [127:0] pt2;
      logic [127:0] pt3;
      bit           found;
      pt  = GOST_PT;
      pt2 = 128'h0123456789abcdeffedcba9876543210;
      pt3 = 128'hdeadbeef00112233cafef00d44556677;
      rstn_i = 1'b0; cmd_valid = 1'b0; cmd_data = '0; res_ready = 1'b0;
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_err", res_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_psel", psel, 1'b0);
      chk("rst_penable", penable, 1'b0);
      chk("rst_pwrite", pwrite, 1'b0);
      chk("rst_paddr", paddr, 12'h0);
      chk("rst_pwdata", pwdata, 32'h0);
      chk("rst_res_data", res_data, 128'h0);
      @(negedge clk);
      rstn_i = 1'b1;

      // First command runs the reset-release write.
      exp_cmd(pt, 1'b1, 2);
      send(pt);
      collect(1'b0, '0);

      exp_cmd(pt2, 1'b0, 2);
      send(pt2);
      collect(1'b0, '0);

      waits = 3;
      exp_cmd(pt, 1'b0, 2);
      send(pt);
      collect(1'b0, '0);
      waits = 0;

      // Slave error on the second data word ends the sequence.
      err_armed = 1;
      err_addr  = 12'h018;
      push_tr(1'b1, 12'h014, pt[31:0]);
      push_tr(1'b1, 12'h018, pt[63:32]);
      push_res(1'b1, '0);
      send(pt);
      collect(1'b0, '0);

      valid_delay = 1;
      exp_cmd(pt, 1'b1, 1);
      send(pt);
      collect(1'b1, pt3);
      exp_cmd(pt3, 1'b0, 1);
      collect(1'b0, '0);

      // Asynchronous reset during the ACCESS phase of the DATA_OUT_1 read.
      valid_delay = 0;
      send(pt);
      found = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(posedge clk);
         #1;
         if (psel && penable && paddr == 12'h028) found = 1;
      end
      chk("found_r28_access", found, 1'b1);
      rstn_i = 1'b0;
      #1;
      chk("midrst_psel", psel, 1'b0);
      chk("midrst_penable", penable, 1'b0);
      chk("midrst_cmd_ready", cmd_ready, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_res_valid", res_valid, 1'b0);
      act_tr.delete();
      exp_tr.delete();
      exp_res.delete();
      @(negedge clk);
      rstn_i = 1'b1;

      exp_cmd(pt, 1'b1, 0);
      send(pt);
      collect(1'b0, '0);

`ifdef KUZ_APB_MASTER_TIMEOUT_EN
      valid_stuck = 1;
      for (int k = 0; k < 4; k++) push_tr(1'b1, 12'h014 + 12'(4 * k), pt[32 * k +: 32]);
      push_tr(1'b1, 12'h004, 32'h1);
      for (int i = 0; i < 4; i++) push_tr(1'b0, 12'h00C, 32'h0);
      push_res(1'b1, '0);
      send(pt);
      collect(1'b0, '0);
      valid_stuck = 0;
      exp_cmd(pt, 1'b1, 0);
      send(pt);
      collect(1'b0, '0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
